regfile_wb_sched: RTL and testbench

REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

---
 rtl/regfile_wb_sched.sv | 157 +++++++++++++++
 tb/tb_regfile_wb_sched.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Register-file write-back scheduler: arbitrates ALU/memory write requests into a FIFO and drains one write per cycle.
// Optional forwarding from queued/in-flight writes is enabled by defining REGFILE_WB_FWD_EN.
module regfile_wb_sched #(
  parameter int DEPTH = 4,
  parameter int NREG  = 16,
  parameter int DW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [3:0]      a_addr,
  input  logic [DW-1:0]   a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [3:0]      b_addr,
  input  logic [DW-1:0]   b_data,
  output logic            b_ready,
  input  logic            wr_stall,
  input  logic [3:0]      rd_addr1,
  input  logic [3:0]      rd_addr2,
  output logic [NREG-1:0] write_reg,
  output logic [DW-1:0]   wr_data,
  output logic [NREG-1:0] read_en1,
  output logic [NREG-1:0] read_en2,
  output logic [2:0]      q_count,
  output logic            q_full,
  output logic            q_empty,
  output logic            fwd_hit1,
  output logic            fwd_hit2,
  output logic [DW-1:0]   fwd_data1,
  output logic [DW-1:0]   fwd_data2
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} gnt_e;

  typedef struct packed {
    logic [3:0]    addr;
    logic [DW-1:0] data;
  } entry_t;

  function automatic logic [NREG-1:0] onehot(input logic [3:0] addr);
    onehot = {{(NREG-1){1'b0}}, 1'b1} << addr;
  endfunction

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, count_d;
  gnt_e            last_q;
  logic [NREG-1:0] write_reg_q;
  logic [DW-1:0]   wr_data_q;

  logic   grant_a, grant_b, accept, push, pop;
  entry_t in_entry;

  assign q_full  = (count_q == CW'(DEPTH));
  assign q_empty = (count_q == '0);
  assign q_count = 3'(count_q);

  // A tie goes to whichever source did not win the previous acceptance.
  assign grant_a = a_valid && (!b_valid || last_q == GNT_B);
  assign grant_b = b_valid && (!a_valid || last_q == GNT_A);
  assign a_ready = !q_full && grant_a;
  assign b_ready = !q_full && grant_b;
  assign accept  = a_ready || b_ready;

  assign in_entry = grant_a ? entry_t'{addr: a_addr, data: a_data}
                            : entry_t'{addr: b_addr, data: b_data};
  // Writes to R0 are acknowledged but never enter the queue.
  assign push = accept && (in_entry.addr != 4'd0);
  assign pop  = !q_empty && !wr_stall;

  always_comb begin
    // NOTE: default assignment first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      last_q      <= GNT_B;
      write_reg_q <= '0;
      wr_data_q   <= '0;
    end else begin
      count_q <= count_d;
      if (accept) last_q <= grant_a ? GNT_A : GNT_B;
      if (push)   tail_q <= tail_q + PW'(1);
      if (pop) begin
        head_q      <= head_q + PW'(1);
        write_reg_q <= onehot(mem_q[head_q].addr);
        wr_data_q   <= mem_q[head_q].data;
      end else begin
        write_reg_q <= '0;
      end
    end
  end

  // NOTE: queue storage is not reset; entries are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= in_entry;
  end

  assign write_reg = write_reg_q;
  assign wr_data   = wr_data_q;
  assign read_en1  = onehot(rd_addr1);
  assign read_en2  = onehot(rd_addr2);

`ifdef REGFILE_WB_FWD_EN
  logic [PW-1:0] idx;

  // Scan output stage first, then queue oldest to youngest, so the youngest match wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    idx       = head_q;
    if (rd_addr1 != 4'd0 && write_reg_q[rd_addr1]) begin
      fwd_hit1  = 1'b1;
      fwd_data1 = wr_data_q;
    end
    if (rd_addr2 != 4'd0 && write_reg_q[rd_addr2]) begin
      fwd_hit2  = 1'b1;
      fwd_data2 = wr_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (rd_addr1 != 4'd0 && mem_q[idx].addr == rd_addr1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = mem_q[idx].data;
        end
        if (rd_addr2 != 4'd0 && mem_q[idx].addr == rd_addr2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = mem_q[idx].data;
        end
      end
    end
  end
`else
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed self-checking bench for regfile_wb_sched (default parameters, forwarding checks follow REGFILE_WB_FWD_EN).
module tb_regfile_wb_sched;

  localparam int DW = 16;
  localparam int NREG = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            a_valid, b_valid, wr_stall;
  logic [3:0]      a_addr, b_addr, rd_addr1, rd_addr2;
  logic [DW-1:0]   a_data, b_data;
  logic            a_ready, b_ready, q_full, q_empty;
  logic            fwd_hit1, fwd_hit2;
  logic [NREG-1:0] write_reg, read_en1, read_en2;
  logic [DW-1:0]   wr_data, fwd_data1, fwd_data2;
  logic [2:0]      q_count;

  int tests = 0;
  int fails = 0;

  regfile_wb_sched #(.DEPTH(4), .NREG(NREG), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wr_stall(wr_stall), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .write_reg(write_reg), .wr_data(wr_data),
    .read_en1(read_en1), .read_en2(read_en2),
    .q_count(q_count), .q_full(q_full), .q_empty(q_empty),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0]    exp_addr [4];
  logic [DW-1:0] exp_data [4];
  logic [NREG-1:0] seen;
  bit fwd_en;

  initial begin
`ifdef REGFILE_WB_FWD_EN
    fwd_en = 1'b1;
`else
    fwd_en = 1'b0;
`endif
    rst = 1'b0; a_valid = 0; b_valid = 0; wr_stall = 0;
    a_addr = 0; b_addr = 0; a_data = 0; b_data = 0; rd_addr1 = 0; rd_addr2 = 0;
    #12;
    check("rst_count", q_count, 0);
    check("rst_empty", q_empty, 1);
    check("rst_full", q_full, 0);
    check("rst_wreg", write_reg, 0);
    check("rst_wdata", wr_data, 0);
    check("rst_fwd", fwd_hit1, 0);
    rst = 1'b1;
    step();

    // Single write from A into an empty queue.
    a_valid = 1; a_addr = 4'd3; a_data = 16'h1234; rd_addr1 = 4'd3;
    #1;
    check("t1_a_ready", a_ready, 1);
    check("t1_read_en1", read_en1, 16'h0008);
    step();
    a_valid = 0;
    check("t1_wreg_early", write_reg, 0);
    check("t1_count", q_count, 1);
    step();
    check("t1_wreg", write_reg, 16'h0008);
    check("t1_wdata", wr_data, 16'h1234);
    check("t1_count_after", q_count, 0);
    step();
    check("t1_wreg_clear", write_reg, 0);
    check("t1_wdata_hold", wr_data, 16'h1234);

    // Fresh reset so A wins the first tie, then alternate grants.
    rst = 0; #1; rst = 1;
    step();
    a_valid = 1; a_addr = 4'd1; a_data = 16'hA001;
    b_valid = 1; b_addr = 4'd2; b_data = 16'hB002;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t2_a_ready%0d", k), a_ready, (k % 2 == 0));
      check($sformatf("t2_b_ready%0d", k), b_ready, (k % 2 == 1));
      step();
      if (k >= 1)
        check($sformatf("t2_wreg%0d", k - 1), write_reg, ((k - 1) % 2 == 0) ? 16'h0002 : 16'h0004);
    end
    a_valid = 0; b_valid = 0;
    step();
    check("t2_wreg3", write_reg, 16'h0004);
    check("t2_wdata3", wr_data, 16'hB002);
    step();
    check("t2_wreg_clear", write_reg, 0);
    check("t2_empty", q_empty, 1);

    // Fill under stall, fifth request refused, then drain in order.
    wr_stall = 1;
    for (int i = 0; i < 5; i++) begin
      a_valid = 1; a_addr = 4'(4 + i); a_data = 16'h0400 + 16'(i);
      if (i < 4) begin
        exp_addr[i] = 4'(4 + i);
        exp_data[i] = 16'h0400 + 16'(i);
      end
      #1;
      check($sformatf("t3_a_ready%0d", i), a_ready, (i < 4));
      step();
    end
    check("t3_full", q_full, 1);
    check("t3_count", q_count, 4);
    check("t3_wreg_stalled", write_reg, 0);
    wr_stall = 0;
    #1;
    check("t3_ready_full_pop", a_ready, 0);
    for (int j = 0; j < 4; j++) begin
      step();
      a_valid = 0;
      check($sformatf("t3_wreg%0d", j), write_reg, 32'(16'h1 << exp_addr[j]));
      check($sformatf("t3_wdata%0d", j), wr_data, exp_data[j]);
      check($sformatf("t3_count%0d", j), q_count, 3 - j);
    end
    step();
    check("t3_wreg_clear", write_reg, 0);
    check("t3_empty", q_empty, 1);

    // R0 write is acknowledged and dropped.
    b_valid = 1; b_addr = 4'd0; b_data = 16'hFFFF;
    #1;
    check("t4_b_ready", b_ready, 1);
    step();
    b_valid = 0;
    check("t4_count", q_count, 0);
    check("t4_wreg0", write_reg, 0);
    step();
    check("t4_wreg1", write_reg, 0);

    // Two writes to R5 held in the queue; forwarding picks the younger.
    wr_stall = 1;
    a_valid = 1; a_addr = 4'd5; a_data = 16'h0A0A;
    step();
    a_data = 16'h0B0B;
    step();
    a_valid = 0;
    rd_addr1 = 4'd5; rd_addr2 = 4'd0;
    #1;
    check("t5_count", q_count, 2);
    check("t5_read_en1", read_en1, 16'h0020);
    check("t5_read_en2", read_en2, 16'h0001);
    check("t5_fwd_hit1", fwd_hit1, fwd_en);
    check("t5_fwd_data1", fwd_data1, fwd_en ? 16'h0B0B : 16'h0000);
    check("t5_fwd_hit2", fwd_hit2, 0);

    // Mid-cycle reset discards the queue; nothing is written afterwards.
    #2;
    rst = 0;
    #1;
    check("t6_empty", q_empty, 1);
    check("t6_count", q_count, 0);
    check("t6_wreg", write_reg, 0);
    check("t6_fwd_hit1", fwd_hit1, 0);
    rst = 1; wr_stall = 0;
    seen = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      seen = seen | write_reg;
    end
    check("t6_no_writes", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
